// File: rtl/config_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_chain_loader
// Purpose  : Streams the configuration bitstream from the host word interface
//            into the serial config scan chain that threads the fabric tiles.
//            Each WORD_WIDTH-bit word is accepted on valid/ready and shifted
//            out LSB-first, one bit per cycle. After the last chain bit, a
//            one-cycle cfg_set pulse tells every tile to latch its shifted
//            config. This block is the fabric's only config source.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WORD_WIDTH : bits per host word (>= 2)
//   CHAIN_LEN  : total config bits in the scan chain (>= 1)
// Ports
//   clk      in   1           config clock, rising edge
//   rst      in   1           synchronous active-high reset
//   start    in   1           one-cycle pulse that begins a new load
//   in_data  in   WORD_WIDTH  config word, bit 0 shifted first
//   in_valid in   1           in_data valid
//   in_ready out  1           word accepted this cycle when in_valid is high
//   cfg_en   out  1           scan-chain shift enable
//   cfg_bit  out  1           serial config data, valid while cfg_en is high
//   cfg_set  out  1           one-cycle latch pulse after the final bit
//   busy     out  1           load in progress
//   done     out  1           last load completed; held until start or rst
// ============================================================================
module config_chain_loader #(
    parameter int WORD_WIDTH = 32,
    parameter int CHAIN_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cfg_en,
    output logic                  cfg_bit,
    output logic                  cfg_set,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int NWORDS    = (CHAIN_LEN + WORD_WIDTH - 1) / WORD_WIDTH;
    // The final word only carries what is left of the chain; its upper bits
    // are never shifted out.
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_WIDTH;
    localparam int WC_W      = $clog2(NWORDS + 1);
    localparam int BL_W      = $clog2(WORD_WIDTH + 1);

    localparam logic [WC_W-1:0] c_NWORDS    = WC_W'(NWORDS);
    localparam logic [WC_W-1:0] c_LAST_IDX  = WC_W'(NWORDS - 1);
    localparam logic [WC_W-1:0] c_WC_ONE    = WC_W'(1);
    localparam logic [BL_W-1:0] c_FULL_BITS = BL_W'(WORD_WIDTH);
    localparam logic [BL_W-1:0] c_LAST_BITS = BL_W'(LAST_BITS);
    localparam logic [BL_W-1:0] c_BL_ONE    = BL_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_SET   = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [WORD_WIDTH-1:0] r_sreg;
    logic [WC_W-1:0]       r_word_cnt;
    logic [BL_W-1:0]       r_bits_left;

    logic                  w_accept;
    logic                  w_last_bit;
    logic                  w_last_word;

    // A word is taken only while parked in LOAD; in_valid elsewhere is ignored.
    assign w_accept    = (r_state == c_ST_LOAD) && in_valid;
    assign w_last_bit  = (r_bits_left == c_BL_ONE);
    // word_cnt has already been bumped for the word currently shifting.
    assign w_last_word = (r_word_cnt == c_NWORDS);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE,
            c_ST_DONE: begin
                if (start) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_last_bit) begin
                    w_state_nxt = w_last_word ? c_ST_SET : c_ST_LOAD;
                end
            end
            c_ST_SET: begin
                w_state_nxt = c_ST_DONE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shift register and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg      <= '0;
            r_word_cnt  <= '0;
            r_bits_left <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE,
                c_ST_DONE: begin
                    if (start) begin
                        r_word_cnt  <= '0;
                        r_bits_left <= '0;
                    end
                end
                c_ST_LOAD: begin
                    if (w_accept) begin
                        r_sreg      <= in_data;
                        r_word_cnt  <= r_word_cnt + c_WC_ONE;
                        // Compare against the pre-increment count to pick the
                        // length of the word being captured now.
                        r_bits_left <= (r_word_cnt == c_LAST_IDX) ? c_LAST_BITS
                                                                  : c_FULL_BITS;
                    end
                end
                c_ST_SHIFT: begin
                    r_sreg      <= {1'b0, r_sreg[WORD_WIDTH-1:1]};
                    r_bits_left <= r_bits_left - c_BL_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded purely from registered state so the tile-facing
    // signals are glitch-free.
    // ------------------------------------------------------------------------
    assign in_ready = (r_state == c_ST_LOAD);
    assign cfg_en   = (r_state == c_ST_SHIFT);
    assign cfg_bit  = (r_state == c_ST_SHIFT) && r_sreg[0];
    assign cfg_set  = (r_state == c_ST_SET);
    assign busy     = (r_state == c_ST_LOAD) || (r_state == c_ST_SHIFT) ||
                      (r_state == c_ST_SET);
    assign done     = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_chain_loader
// Purpose  : Self-checking bench for config_chain_loader. Three instances
//            (WORD_WIDTH=16; CHAIN_LEN=40, 32 and 1). Expected chain bits are
//            queued as words are handed over and popped on every cfg_en cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_chain_loader;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  start;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  cfg_en;
    logic [2:0]  cfg_bit;
    logic [2:0]  cfg_set;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [15:0] in_data [3];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int en_cnt  [3];
    int set_cnt [3];

    bit sb0 [$];
    bit sb1 [$];
    bit sb2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    config_chain_loader #(.WORD_WIDTH(16), .CHAIN_LEN(40)) u_dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .cfg_en(cfg_en[0]),
        .cfg_bit(cfg_bit[0]), .cfg_set(cfg_set[0]), .busy(busy[0]), .done(done[0])
    );

    config_chain_loader #(.WORD_WIDTH(16), .CHAIN_LEN(32)) u_dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .cfg_en(cfg_en[1]),
        .cfg_bit(cfg_bit[1]), .cfg_set(cfg_set[1]), .busy(busy[1]), .done(done[1])
    );

    config_chain_loader #(.WORD_WIDTH(16), .CHAIN_LEN(1)) u_dut_c (
        .clk(clk), .rst(rst[2]), .start(start[2]), .in_data(in_data[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .cfg_en(cfg_en[2]),
        .cfg_bit(cfg_bit[2]), .cfg_set(cfg_set[2]), .busy(busy[2]), .done(done[2])
    );

    // ------------------------------------------------------------------------
    // Per-instance constants
    // ------------------------------------------------------------------------
    function automatic int clen(input int k);
        case (k)
            0: return 40;
            1: return 32;
            default: return 1;
        endcase
    endfunction

    function automatic int nw(input int k);
        case (k)
            0: return 3;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int lastb(input int k);
        return clen(k) - (nw(k) - 1) * 16;
    endfunction

    // ------------------------------------------------------------------------
    // Scoreboard queues
    // ------------------------------------------------------------------------
    function automatic void sb_push(input int k, input bit b);
        case (k)
            0: sb0.push_back(b);
            1: sb1.push_back(b);
            default: sb2.push_back(b);
        endcase
    endfunction

    function automatic int sb_size(input int k);
        case (k)
            0: return sb0.size();
            1: return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    function automatic bit sb_pop(input int k);
        case (k)
            0: return sb0.pop_front();
            1: return sb1.pop_front();
            default: return sb2.pop_front();
        endcase
    endfunction

    function automatic void sb_flush(input int k);
        case (k)
            0: sb0.delete();
            1: sb1.delete();
            default: sb2.delete();
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Output monitor: pops one expected bit per shift cycle
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cfg_set[k]) set_cnt[k]++;
            vectors++;
            if (cfg_en[k]) begin
                en_cnt[k]++;
                if (sb_size(k) == 0) begin
                    errors++;
                    $display("FAIL extra_shift dut%0d cyc%0d: cfg_en=1 cfg_bit=%0b, required no shift", k, cyc, cfg_bit[k]);
                end else begin
                    bit exp_bit;
                    exp_bit = sb_pop(k);
                    if (cfg_bit[k] !== exp_bit) begin
                        errors++;
                        $display("FAIL cfg_bit dut%0d cyc%0d: got %0b, required %0b", k, cyc, cfg_bit[k], exp_bit);
                    end
                end
            end else if (cfg_bit[k] !== 1'b0) begin
                errors++;
                $display("FAIL cfg_bit_idle dut%0d cyc%0d: got %0b, required 0", k, cyc, cfg_bit[k]);
            end
            if ((in_ready[k] && cfg_en[k]) || (in_ready[k] && !busy[k])) begin
                vectors++;
                errors++;
                $display("FAIL ready_phase dut%0d cyc%0d: in_ready=%0b cfg_en=%0b busy=%0b, required ready only in LOAD", k, cyc, in_ready[k], cfg_en[k], busy[k]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic pulse_start(input int k);
        @(posedge clk); #1 start[k] = 1'b1;
        @(posedge clk); #1 start[k] = 1'b0;
    endtask

    // Hands nstop words to instance k; queues expected bits on each handshake.
    task automatic feed(input int k, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input bit rnd, input int nstop,
                        output int load_cyc);
        logic [15:0] w [3];
        logic [15:0] cur;
        int idx;
        int guard;
        int nbits;
        w[0] = w0; w[1] = w1; w[2] = w2;
        idx = 0; guard = 0; load_cyc = -1;
        in_data[k]  = w[0];
        in_valid[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (idx < nstop && guard < 500) begin
            @(negedge clk);
            if (in_ready[k] && load_cyc < 0) load_cyc = cyc;
            if (in_ready[k] && in_valid[k]) begin
                nbits = (idx == nw(k) - 1) ? lastb(k) : 16;
                cur   = w[idx];
                for (int b = 0; b < nbits; b++) sb_push(k, cur[b]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < nstop) in_data[k] = w[idx];
            in_valid[k] = (idx < nstop) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            guard++;
        end
        if (idx < nstop) begin
            vectors++;
            errors++;
            $display("FAIL feed_timeout dut%0d: accepted %0d words, required %0d", k, idx, nstop);
        end
    endtask

    // Full load: start, feed all words, wait for cfg_set, check the wrap-up.
    task automatic do_full_load(input int k, input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input bit rnd, input int mid_start);
        int load_cyc;
        int set_cyc;
        en_cnt[k]  = 0;
        set_cnt[k] = 0;
        pulse_start(k);
        fork
            feed(k, w0, w1, w2, rnd, nw(k), load_cyc);
            begin
                if (mid_start > 0) begin
                    repeat (mid_start) @(posedge clk);
                    #1 start[k] = 1'b1;
                    @(posedge clk); #1 start[k] = 1'b0;
                end
            end
        join
        set_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cfg_set[k]) begin
                set_cyc = cyc;
                break;
            end
        end
        vectors++;
        if (set_cyc < 0) begin
            errors++;
            $display("FAIL set_timeout dut%0d: cfg_set never seen within 200 cycles", k);
        end else if (!rnd && (set_cyc - load_cyc + 1) != nw(k) + clen(k) + 1) begin
            errors++;
            $display("FAIL set_timing dut%0d: cfg_set at LOAD-relative cycle %0d, required %0d", k, set_cyc - load_cyc + 1, nw(k) + clen(k) + 1);
        end
        @(negedge clk);
        vectors++;
        if (done[k] !== 1'b1 || busy[k] !== 1'b0 || cfg_set[k] !== 1'b0 || in_ready[k] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_up dut%0d: done=%0b busy=%0b cfg_set=%0b in_ready=%0b, required 1 0 0 0", k, done[k], busy[k], cfg_set[k], in_ready[k]);
        end
        vectors++;
        if (en_cnt[k] != clen(k) || set_cnt[k] != 1 || sb_size(k) != 0) begin
            errors++;
            $display("FAIL counts dut%0d: cfg_en cycles=%0d set pulses=%0d leftover bits=%0d, required %0d 1 0", k, en_cnt[k], set_cnt[k], sb_size(k), clen(k));
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({in_ready[k], cfg_en[k], cfg_bit[k], cfg_set[k], busy[k], done[k]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %06b, required 000000", k,
                         {in_ready[k], cfg_en[k], cfg_bit[k], cfg_set[k], busy[k], done[k]});
            end
        end
        @(posedge clk); #1 rst = 3'b000;
    endtask

    task automatic test_basic_load();
        do_full_load(0, 16'hA5C3, 16'h0F0F, 16'hFF12, 1'b0, 0);
    endtask

    task automatic test_random_valid();
        do_full_load(0, 16'hA5C3, 16'h0F0F, 16'hFF12, 1'b1, 0);
    endtask

    task automatic test_start_mid_shift();
        do_full_load(0, 16'h1357, 16'h9BDF, 16'h00E4, 1'b0, 6);
    endtask

    task automatic test_reset_mid_load();
        int load_cyc;
        pulse_start(0);
        feed(0, 16'hDEAD, 16'hBEEF, 16'hC0DE, 1'b0, 2, load_cyc);
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({in_ready[0], cfg_en[0], cfg_bit[0], cfg_set[0], busy[0], done[0]} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_load: outputs %06b, required 000000",
                     {in_ready[0], cfg_en[0], cfg_bit[0], cfg_set[0], busy[0], done[0]});
        end
        sb_flush(0);
        @(posedge clk); #1 rst[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b done=%0b, required 0 0", busy[0], done[0]);
        end
        do_full_load(0, 16'hA5C3, 16'h0F0F, 16'hFF12, 1'b0, 0);
    endtask

    task automatic test_exact_multiple();
        do_full_load(1, 16'h1234, 16'hBEEF, 16'h0000, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (done[1] !== 1'b1) begin
                errors++;
                $display("FAIL done_hold cyc%0d: done=%0b, required 1", cyc, done[1]);
            end
        end
        pulse_start(1);
        @(negedge clk);
        vectors++;
        if (done[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL start_clears_done: done=%0b in_ready=%0b, required 0 1", done[1], in_ready[1]);
        end
        @(posedge clk); #1 rst[1] = 1'b1;
        @(posedge clk); #1 rst[1] = 1'b0;
    endtask

    task automatic test_single_bit();
        do_full_load(2, 16'h0001, 16'h0000, 16'h0000, 1'b0, 0);
        do_full_load(2, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        do_full_load(0, 16'h8001, 16'h7FFE, 16'h5AA5, 1'b0, 0);
        do_full_load(0, 16'hFFFF, 16'h0000, 16'h00FF, 1'b0, 0);
    endtask

    initial begin
        rst      = 3'b111;
        start    = 3'b000;
        in_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            in_data[k] = 16'h0000;
            en_cnt[k]  = 0;
            set_cnt[k] = 0;
        end
        test_reset();
        test_basic_load();
        test_random_valid();
        test_start_mid_shift();
        test_reset_mid_load();
        test_exact_multiple();
        test_single_bit();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
